// File: rtl/debounce_scan_ctrl.sv
// debounce_scan_ctrl: round-robin time-multiplexed debouncer.
// One prescaled scan engine shares a compare/increment datapath.
module debounce_scan_ctrl #(
   parameter  int WIDTH        = 8,
   parameter  int PRESCALE     = 200,
   parameter  int STABLE_COUNT = 4,
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1,
   localparam int NW = $clog2(STABLE_COUNT + 1)
) (
   input  logic             clk,
   input  logic             anrst,
   input  logic             ena,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             scan_stb,
   output logic [CW-1:0]    scan_ch
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      EVAL
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] in_m;
   logic [WIDTH-1:0] in_s;
   logic [PW-1:0]    presc;
   logic [PW-1:0]    presc_nxt;
   logic [NW-1:0]    cnt [WIDTH];
   logic [NW-1:0]    cnt_nxt;
   logic [CW-1:0]    ch_nxt;
   logic             smp;
   logic             cur;
   logic             flip;

   always_comb begin
      state = IDLE;
      if (ena) begin
         state = (int'(presc) == PRESCALE - 1) ? EVAL : WAIT;
      end
   end

   // gated by reset so PRESCALE=1 cannot strobe while held in reset
   assign scan_stb = anrst & (state == EVAL);

   always_comb begin
      presc_nxt = presc;
      ch_nxt    = scan_ch;
      smp       = in_s[scan_ch];
      cur       = out[scan_ch];
      cnt_nxt   = cnt[scan_ch];
      flip      = 1'b0;
      unique case (state)
         IDLE: ;
         WAIT: presc_nxt = presc + 1'b1;
         EVAL: begin
            presc_nxt = '0;
            if (int'(scan_ch) == WIDTH - 1) begin
               ch_nxt = '0;
            end else begin
               ch_nxt = scan_ch + 1'b1;
            end
            if (smp == cur) begin
               cnt_nxt = '0;
            end else if (int'(cnt[scan_ch]) + 1 == STABLE_COUNT) begin
               cnt_nxt = '0;
               flip    = 1'b1;
            end else begin
               cnt_nxt = cnt[scan_ch] + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         in_m    <= '0;
         in_s    <= '0;
         presc   <= '0;
         scan_ch <= '0;
         out     <= '0;
         rise    <= '0;
         fall    <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         in_m         <= in;
         in_s         <= in_m;
         presc        <= presc_nxt;
         scan_ch      <= ch_nxt;
         cnt[scan_ch] <= cnt_nxt;
         rise         <= '0;
         fall         <= '0;
         if (flip) begin
            out[scan_ch]  <= smp;
            rise[scan_ch] <= smp;
            fall[scan_ch] <= ~smp;
         end
      end
   end

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// tb_debounce_scan_ctrl: directed scenarios plus random stimulus,
// checked every cycle against a behavioural scan/debounce model.
module tb_debounce_scan_ctrl;

   localparam int W  = 4;
   localparam int P  = 3;
   localparam int SC = 2;

   logic         clk   = 1'b0;
   logic         anrst = 1'b0;
   logic         ena   = 1'b1;
   logic [W-1:0] in    = '0;
   logic [W-1:0] out;
   logic [W-1:0] rise;
   logic [W-1:0] fall;
   logic         scan_stb;
   logic [1:0]   scan_ch;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   debounce_scan_ctrl #(
      .WIDTH        (W),
      .PRESCALE     (P),
      .STABLE_COUNT (SC)
   ) dut (
      .clk      (clk),
      .anrst    (anrst),
      .ena      (ena),
      .in       (in),
      .out      (out),
      .rise     (rise),
      .fall     (fall),
      .scan_stb (scan_stb),
      .scan_ch  (scan_ch)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_rng(input string nm, input int v, input int lo, input int hi);
      checks++;
      if (v < lo || v > hi) begin
         errors++;
         $display("FAIL %s: got %0d required %0d..%0d at %0t", nm, v, lo, hi, $time);
      end
   endtask

   // model: e = enabled cycles since reset; evaluations at e%P==P-1
   int           m_e   = 0;
   logic [W-1:0] m_s1  = '0;
   logic [W-1:0] m_s2  = '0;
   logic [W-1:0] m_out = '0;
   logic [W-1:0] m_rise = '0;
   logic [W-1:0] m_fall = '0;
   int           m_run [W] = '{default: 0};
   int           m_c;
   logic         m_stb;

   always_comb m_c = (m_e / P) % W;
   always_comb m_stb = anrst && ena && (m_e % P == P - 1);

   always @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         m_e    <= 0;
         m_s1   <= '0;
         m_s2   <= '0;
         m_out  <= '0;
         m_rise <= '0;
         m_fall <= '0;
         for (int i = 0; i < W; i++) m_run[i] <= 0;
      end else begin
         m_s1   <= in;
         m_s2   <= m_s1;
         m_rise <= '0;
         m_fall <= '0;
         if (ena) m_e <= m_e + 1;
         if (m_stb) begin
            if (m_s2[m_c] == m_out[m_c]) begin
               m_run[m_c] <= 0;
            end else if (m_run[m_c] + 1 >= SC) begin
               m_run[m_c] <= 0;
               m_out[m_c] <= m_s2[m_c];
               if (m_s2[m_c]) m_rise[m_c] <= 1'b1;
               else m_fall[m_c] <= 1'b1;
            end else begin
               m_run[m_c] <= m_run[m_c] + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("cyc_out", int'(out), int'(m_out));
      chk("cyc_rise", int'(rise), int'(m_rise));
      chk("cyc_fall", int'(fall), int'(m_fall));
      chk("cyc_stb", int'(scan_stb), int'(m_stb));
      chk("cyc_ch", int'(scan_ch), m_c);
   end

   task automatic release_rst();
      @(posedge clk);
      #3 anrst = 1'b1;
   endtask

   task automatic hit_rst();
      @(posedge clk);
      #2 anrst = 1'b0;
      in  = '0;
      ena = 1'b1;
   endtask

   task automatic scan_seq(input string tag);
      int e_ch  [15] = '{0,0,0,1,1,1,2,2,2,3,3,3,0,0,0};
      int e_stb [15] = '{0,0,1,0,0,1,0,0,1,0,0,1,0,0,1};
      #1;
      for (int k = 0; k < 15; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         chk({tag, "_stb"}, int'(scan_stb), e_stb[k]);
         chk({tag, "_ch"}, int'(scan_ch), e_ch[k]);
         chk({tag, "_out"}, int'(out), 0);
      end
   endtask

   task automatic wait_bit(input int idx, input logic val, input int maxn,
                           output int n);
      n = -1;
      for (int k = 1; k <= maxn; k++) begin
         @(posedge clk);
         #1;
         if (out[idx] === val) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic measure(input bit drop, output int lat);
      int hold;
      hit_rst();
      release_rst();
      repeat (5) @(posedge clk);
      #1 in[1] = 1'b1;
      lat  = -1;
      hold = 0;
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk);
         #1;
         if (out[1]) begin
            lat = k;
            break;
         end
         if (drop && k >= 5 && k <= 14) begin
            chk("s5_hold_ch", int'(scan_ch), hold);
            chk("s5_no_stb", int'(scan_stb), 0);
         end
         if (drop && k == 4) begin
            ena  = 1'b0;
            hold = int'(scan_ch);
         end
         if (drop && k == 14) ena = 1'b1;
      end
   endtask

   int n;
   int l0;
   int l1;
   int nch;
   int t [4];
   int chs [4];
   bit seen;
   int idx;

   initial begin
      anrst = 1'b0;
      ena   = 1'b1;
      in    = '0;
      release_rst();
      scan_seq("s1");

      repeat (5) @(posedge clk);
      #1 in[1] = 1'b1;
      wait_bit(1, 1'b1, 40, n);
      chk_rng("s2_rise_lat", n, 15, 27);
      chk("s2_rise1", int'(rise), 2);
      chk("s2_fall0", int'(fall), 0);
      chk("s2_out", int'(out), 2);
      @(posedge clk);
      #1;
      chk("s2_rise_end", int'(rise), 0);
      in[1] = 1'b0;
      wait_bit(1, 1'b0, 40, n);
      chk_rng("s2_fall_lat", n, 15, 27);
      chk("s2_fall1", int'(fall), 2);
      chk("s2_rise0", int'(rise), 0);
      @(posedge clk);
      #1;
      chk("s2_fall_end", int'(fall), 0);

      in[2] = 1'b1;
      repeat (6) @(posedge clk);
      #1 in[2] = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out[2] || rise != 0) seen = 1'b1;
      end
      chk("s3_glitch", int'(seen), 0);

      in  = 4'hF;
      nch = 0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (rise != 0 || fall != 0) begin
            chk("s4_onehot", $countones(rise), 1);
            chk("s4_fall", int'(fall), 0);
            idx = 0;
            for (int b = 0; b < W; b++) if (rise[b]) idx = b;
            if (nch < 4) begin
               t[nch]   = k;
               chs[nch] = idx;
            end
            nch++;
         end
      end
      chk("s4_nchg", nch, 4);
      for (int i = 1; i < 4; i++) begin
         chk("s4_gap", t[i] - t[i-1], 3);
         chk("s4_order", chs[i], (chs[i-1] + 1) % 4);
      end
      chk("s4_final", int'(out), 15);

      measure(1'b0, l0);
      chk_rng("s5_base_lat", l0, 15, 27);
      measure(1'b1, l1);
      chk("s5_lat_plus10", l1, l0 + 10);

      hit_rst();
      release_rst();
      in = 4'h5;
      wait_bit(0, 1'b1, 60, n);
      repeat (30) @(posedge clk);
      #1;
      chk("s6_pre_out", int'(out), 5);
      in = 4'h7;
      n  = -1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (m_run[1] == 1) begin
            n = k;
            break;
         end
      end
      chk("s6_cnt_reached", int'(n > 0), 1);
      chk("s6_out5", int'(out), 5);
      @(posedge clk);
      #2 anrst = 1'b0;
      #1;
      chk("s6_rst_out", int'(out), 0);
      chk("s6_rst_ch", int'(scan_ch), 0);
      chk("s6_rst_stb", int'(scan_stb), 0);
      chk("s6_rst_rf", int'(rise | fall), 0);
      in = '0;
      release_rst();
      scan_seq("s6");

      for (int k = 0; k < 500; k++) begin
         @(posedge clk);
         #1;
         if ($urandom_range(0, 15) == 0) begin
            idx = $urandom_range(0, W - 1);
            in[idx] = ~in[idx];
         end
         ena = ($urandom_range(0, 9) != 0);
      end
      ena = 1'b1;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

endmodule
